// File: rtl/sprite_anim_sequencer_pkg.sv
// Shared sprite-sheet geometry, sequencer state type and row helpers.
// The icon renderer imports this package so both sides agree on the sheet layout.
package sprite_pkg;

    localparam int unsigned SPRITE_COLS    = 34;
    localparam int unsigned SPRITE_ROWS    = 34;
    localparam int unsigned NUM_COLS       = 3;
    localparam int unsigned NUM_ROWS       = 8;
    localparam int unsigned MEM_COLS       = SPRITE_COLS * NUM_COLS;
    localparam int unsigned FRAME_ROW_SIZE = MEM_COLS * SPRITE_ROWS;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        SHOT
    } anim_state_t;

    // Heading (N, NE, E, SE, S, SW, W, NW) to the sheet row drawn for it
    function automatic logic [2:0] orient_to_row(input logic [2:0] orient);
        logic [2:0] row;
        case (orient)
            3'd0:    row = 3'd1;
            3'd1:    row = 3'd7;
            3'd2:    row = 3'd3;
            3'd3:    row = 3'd5;
            3'd4:    row = 3'd0;
            3'd5:    row = 3'd4;
            3'd6:    row = 3'd2;
            default: row = 3'd6;
        endcase
        return row;
    endfunction

    // Out-of-range one-shot rows fall back to the last row of the sheet
    function automatic logic [2:0] clamp_row(input logic [2:0] row, input int unsigned num_rows);
        logic [2:0] res;
        if (32'(row) >= num_rows) res = 3'(num_rows - 1);
        else                      res = row;
        return res;
    endfunction

endpackage

// File: rtl/sprite_anim_sequencer_tick.sv
// Animation frame prescaler: fires one tick every ANIMATION_COUNTDOWN+1 enabled clocks.
module anim_tick_gen #(
    parameter int unsigned ANIMATION_COUNTDOWN = 8_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic reload,
    output logic tick
);

    localparam int unsigned   CW     = (ANIMATION_COUNTDOWN > 0) ? $clog2(ANIMATION_COUNTDOWN + 1) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(ANIMATION_COUNTDOWN);

    logic [CW-1:0] count;

    assign tick = en && (count == '0);

    // Down-counter: reload on tick or request, hold while disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               count <= RELOAD;
        else if (reload || tick) count <= RELOAD;
        else if (en)             count <= count - CW'(1);
    end

endmodule

// File: rtl/sprite_anim_sequencer.sv
// Robot icon animation sequencer: walk ping-pong, one-shot action rows and
// the registered frame base address for the sprite RAM address adder.
module sprite_anim_sequencer
    import sprite_pkg::*;
#(
    parameter int unsigned ANIMATION_COUNTDOWN = 8_000_000,
    parameter int unsigned SPRITE_COLS         = sprite_pkg::SPRITE_COLS,
    parameter int unsigned SPRITE_ROWS         = sprite_pkg::SPRITE_ROWS,
    parameter int unsigned NUM_COLS            = sprite_pkg::NUM_COLS,
    parameter int unsigned NUM_ROWS            = sprite_pkg::NUM_ROWS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        moving,
    input  logic [2:0]  orient,
    input  logic        shot_req,
    input  logic [2:0]  shot_row,
    output logic [2:0]  frame_row,
    output logic [1:0]  frame_col,
    output logic [31:0] frame_base,
    output logic        busy,
    output logic        shot_done
);

    localparam int unsigned ROW_STRIDE = SPRITE_COLS * NUM_COLS * SPRITE_ROWS;
    localparam logic [1:0]  LAST_COL   = 2'(NUM_COLS - 1);
    localparam logic [31:0] BASE_RESET = 32'(3 * ROW_STRIDE + SPRITE_COLS);

    anim_state_t state;
    anim_state_t state_next;
    logic [2:0]  row_next;
    logic [1:0]  col_next;
    logic        dir_up;
    logic        dir_up_next;
    logic        busy_next;
    logic        done_next;
    logic        tick;
    logic        tick_en;
    logic        tick_reload;

    // Prescaler runs outside IDLE and restarts on every state entry
    assign tick_en     = (state != IDLE);
    assign tick_reload = (state_next != state);

    anim_tick_gen #(
        .ANIMATION_COUNTDOWN(ANIMATION_COUNTDOWN)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .en     (tick_en),
        .reload (tick_reload),
        .tick   (tick)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and next frame selection; shot_req outranks motion changes
    always_comb begin
        state_next  = state;
        row_next    = frame_row;
        col_next    = frame_col;
        dir_up_next = dir_up;
        done_next   = 1'b0;
        case (state)
            IDLE: begin
                row_next    = orient_to_row(orient);
                col_next    = 2'd1;
                dir_up_next = 1'b1;
                if (shot_req) begin
                    state_next = SHOT;
                    col_next   = 2'd0;
                    row_next   = clamp_row(shot_row, NUM_ROWS);
                end else if (moving) begin
                    state_next = WALK;
                end
            end
            WALK: begin
                row_next = orient_to_row(orient);
                if (shot_req) begin
                    state_next = SHOT;
                    col_next   = 2'd0;
                    row_next   = clamp_row(shot_row, NUM_ROWS);
                end else if (!moving) begin
                    state_next  = IDLE;
                    col_next    = 2'd1;
                    dir_up_next = 1'b1;
                end else if (tick) begin
                    col_next = dir_up ? frame_col + 2'd1 : frame_col - 2'd1;
                    if (col_next == LAST_COL)  dir_up_next = 1'b0;
                    else if (col_next == 2'd0) dir_up_next = 1'b1;
                end
            end
            SHOT: begin
                if (tick) begin
                    if (frame_col == LAST_COL) begin
                        done_next   = 1'b1;
                        col_next    = 2'd1;
                        dir_up_next = 1'b1;
                        state_next  = moving ? WALK : IDLE;
                    end else begin
                        col_next = frame_col + 2'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next == SHOT);
    end

    // Registered outputs; frame_base is built from the already-registered row/col
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_row  <= 3'd3;
            frame_col  <= 2'd1;
            frame_base <= BASE_RESET;
            dir_up     <= 1'b1;
            busy       <= 1'b0;
            shot_done  <= 1'b0;
        end else begin
            frame_row  <= row_next;
            frame_col  <= col_next;
            frame_base <= 32'(frame_row) * ROW_STRIDE + 32'(frame_col) * SPRITE_COLS;
            dir_up     <= dir_up_next;
            busy       <= busy_next;
            shot_done  <= done_next;
        end
    end

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Self-checking bench for sprite_anim_sequencer with a short frame period.
module tb_sprite_anim_sequencer;
    import sprite_pkg::*;

    localparam int unsigned CD  = 3;
    localparam int unsigned NC  = 3;
    localparam int unsigned NR  = 8;
    localparam int unsigned SC  = 34;
    localparam int unsigned FRS = 34 * 3 * 34;

    logic        clk = 1'b0;
    logic        reset;
    logic        moving;
    logic [2:0]  orient;
    logic        shot_req;
    logic [2:0]  shot_row;
    logic [2:0]  frame_row;
    logic [1:0]  frame_col;
    logic [31:0] frame_base;
    logic        busy;
    logic        shot_done;

    always #5 clk = ~clk;

    sprite_anim_sequencer #(
        .ANIMATION_COUNTDOWN(CD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .moving     (moving),
        .orient     (orient),
        .shot_req   (shot_req),
        .shot_row   (shot_row),
        .frame_row  (frame_row),
        .frame_col  (frame_col),
        .frame_base (frame_base),
        .busy       (busy),
        .shot_done  (shot_done)
    );

    int total = 0;
    int bad   = 0;
    int done_seen;

    int unsigned row_map [8] = '{1, 7, 3, 5, 0, 4, 2, 6};

    // Reference model: mode flags, time spent in the current frame, walk phase
    bit          m_walk, m_shot;
    int unsigned m_age, m_phase;
    int unsigned m_row, m_col, m_base;
    bit          m_busy, m_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Walk visits 1,2,...,NC-1,...,1,0,1,... as a reflected triangle wave
    function automatic int unsigned walk_col(input int unsigned p);
        int unsigned per = 2 * (NC - 1);
        int unsigned s   = (1 + p) % per;
        return (s <= NC - 1) ? s : per - s;
    endfunction

    task automatic model_reset();
        m_walk = 0; m_shot = 0; m_age = 0; m_phase = 0;
        m_row = 3; m_col = 1; m_base = 3 * FRS + SC;
        m_busy = 0; m_done = 0;
    endtask

    task automatic model_update();
        int unsigned nb;
        bit tk;
        if (reset) begin
            model_reset();
            return;
        end
        nb = m_row * FRS + m_col * SC;
        tk = (m_walk || m_shot) && (m_age == CD);
        m_done = 0;
        if (m_shot) begin
            if (tk) begin
                m_age = 0;
                if (m_col == NC - 1) begin
                    m_done = 1; m_col = 1; m_phase = 0;
                    m_shot = 0; m_walk = moving;
                end else begin
                    m_col++;
                end
            end else begin
                m_age++;
            end
        end else begin
            m_row = row_map[orient];
            if (shot_req) begin
                m_shot = 1; m_walk = 0; m_col = 0; m_age = 0;
                m_row = (int'(shot_row) >= NR) ? NR - 1 : shot_row;
            end else if (m_walk) begin
                if (!moving) begin
                    m_walk = 0; m_col = 1; m_phase = 0;
                end else if (tk) begin
                    m_phase = (m_phase + 1) % (2 * (NC - 1));
                    m_col = walk_col(m_phase);
                    m_age = 0;
                end else begin
                    m_age++;
                end
            end else begin
                m_col = 1;
                if (moving) begin
                    m_walk = 1; m_age = 0; m_phase = 0;
                end
            end
        end
        m_busy = m_shot;
        m_base = nb;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_row"},  32'(frame_row), m_row);
        check({tag, "_col"},  32'(frame_col), m_col);
        check({tag, "_base"}, frame_base,     m_base);
        check({tag, "_busy"}, 32'(busy),      32'(m_busy));
        check({tag, "_done"}, 32'(shot_done), 32'(m_done));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check_all(tag);
        if (shot_done) done_seen++;
    endtask

    initial begin
        reset = 1'b1; moving = 1'b0; orient = 3'd2; shot_req = 1'b0; shot_row = 3'd0;
        model_reset();
        #12;
        check_all("reset");
        check("reset_base_const", frame_base, 32'd10438);
        @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset with heading E
        repeat (20) step("idle");
        check("idle_base_const", frame_base, 32'd10438);
        check("idle_col_const", 32'(frame_col), 32'd1);

        // Walk ping-pong, then drop moving mid-frame
        moving = 1'b1;
        repeat (22) step("walk");
        moving = 1'b0;
        step("walk_stop");
        check("walk_stop_col", 32'(frame_col), 32'd1);
        repeat (3) step("idle2");

        // One-shot from WALK, with a second request ignored while busy
        moving = 1'b1;
        repeat (6) step("walk2");
        done_seen = 0;
        shot_req = 1'b1; shot_row = 3'd6;
        step("shot_acc");
        shot_req = 1'b0;
        check("shot_busy", 32'(busy), 32'd1);
        check("shot_row6", 32'(frame_row), 32'd6);
        repeat (2) step("shot");
        shot_req = 1'b1; shot_row = 3'd2;
        step("shot_ignored");
        shot_req = 1'b0;
        repeat (13) step("shot_tail");
        check("shot_done_once", 32'(done_seen), 32'd1);
        check("shot_exit_busy", 32'(busy), 32'd0);
        repeat (3) step("walk3");

        // Reset on the second SHOT tick aborts without shot_done
        shot_req = 1'b1; shot_row = 3'd5;
        step("shot2_acc");
        shot_req = 1'b0;
        repeat (2 * (CD + 1) - 1) step("shot2");
        check("shot2_col_before_reset", 32'(frame_col), 32'd1);
        reset = 1'b1;
        #1;
        model_reset();
        check_all("abort");
        step("abort_hold");
        reset = 1'b0;
        repeat (12) step("restart");

        // Heading sweep in IDLE
        moving = 1'b0;
        repeat (2) step("to_idle");
        for (int o = 0; o < 8; o++) begin
            orient = 3'(o);
            step("sweep");
            check("sweep_row", 32'(frame_row), row_map[o]);
            step("sweep2");
            check("sweep_base", frame_base, row_map[o] * FRS + SC);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0) moving = ~moving;
            orient   = 3'($urandom_range(7));
            shot_req = ($urandom_range(11) == 0);
            shot_row = 3'($urandom_range(7));
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
